// File: rtl/cordic_arbiter.sv
// Round-robin arbiter sharing one CORDIC vectoring core among NUM_REQ requesters; results are routed back via an in-order tag FIFO.
// Optional macro CORDIC_ARB_ERR_EN enables the sticky spurious-result / overflow flag on err_out.
module cordic_arbiter #(
  parameter int NUM_REQ    = 4,
  parameter int DATA_WIDTH = 32
) (
  input  logic                                clk_in,
  input  logic                                rst_n_in,
  input  logic [NUM_REQ-1:0]                  req_valid_in,
  input  logic [NUM_REQ*DATA_WIDTH-1:0]       req_data_in,
  output logic [NUM_REQ-1:0]                  req_ready_out,
  output logic [DATA_WIDTH-1:0]               cordic_tdata_out,
  output logic                                cordic_tvalid_out,
  input  logic                                cordic_tready_in,
  input  logic [DATA_WIDTH-1:0]               cordic_dout_in,
  input  logic                                cordic_dout_valid_in,
  output logic [NUM_REQ*(DATA_WIDTH/2)-1:0]   resp_angle_out,
  output logic [NUM_REQ-1:0]                  resp_valid_out,
  input  logic [NUM_REQ-1:0]                  resp_ready_in,
  output logic                                err_out
);

  localparam int HW = DATA_WIDTH / 2;
  localparam int IW = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;
  localparam int CW = $clog2(NUM_REQ + 1);

  typedef enum logic {
    ST_ARB   = 1'b0,
    ST_ISSUE = 1'b1
  } state_e;

  state_e             state_q, state_d;
  logic [IW-1:0]      rr_ptr_q, tag_q, grant_idx, cand;
  logic               grant_found;
  logic [NUM_REQ-1:0] pending_q, eligible, consume;
  logic               accept, handshake, push, pop, full, empty;
  logic [IW-1:0]      fifo_mem [NUM_REQ];
  logic [IW-1:0]      wr_ptr_q, rd_ptr_q, head_tag;
  logic [CW-1:0]      count_q;
  logic               unused_dout_lo;

  function automatic logic [IW-1:0] wrap_inc(input logic [IW-1:0] v);
    return (v == IW'(NUM_REQ - 1)) ? '0 : v + IW'(1);
  endfunction

  // Handshakes: a transfer happens on a cycle where valid and ready are both 1.
  // Requesters see a one-cycle ready pulse; the CORDIC side holds tdata/tvalid until tready.
  assign eligible = req_valid_in & ~pending_q;
  assign consume  = resp_valid_out & resp_ready_in;

  always_comb begin
    grant_found = 1'b0;
    grant_idx   = '0;
    cand        = rr_ptr_q;
    for (int k = 0; k < NUM_REQ; k++) begin
      if (!grant_found && eligible[cand]) begin
        grant_found = 1'b1;
        grant_idx   = cand;
      end
      cand = wrap_inc(cand);
    end
  end

  always_comb begin
    state_d       = state_q;
    req_ready_out = '0;
    accept        = 1'b0;
    handshake     = 1'b0;
    case (state_q)
      ST_ARB: begin
        if (grant_found) begin
          accept                   = 1'b1;
          req_ready_out[grant_idx] = 1'b1;
          state_d                  = ST_ISSUE;
        end
      end
      ST_ISSUE: begin
        if (cordic_tready_in) begin
          handshake = 1'b1;
          state_d   = ST_ARB;
        end
      end
    endcase
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      state_q           <= ST_ARB;
      rr_ptr_q          <= '0;
      tag_q             <= '0;
      cordic_tdata_out  <= '0;
      cordic_tvalid_out <= 1'b0;
      pending_q         <= '0;
    end else begin
      state_q   <= state_d;
      pending_q <= (pending_q & ~consume) | req_ready_out;
      if (accept) begin
        cordic_tdata_out  <= req_data_in[int'(grant_idx)*DATA_WIDTH +: DATA_WIDTH];
        cordic_tvalid_out <= 1'b1;
        tag_q             <= grant_idx;
        rr_ptr_q          <= wrap_inc(grant_idx);
      end else if (handshake) begin
        cordic_tvalid_out <= 1'b0;
      end
    end
  end

  // Tag FIFO: pop decisions use the occupancy registered at the start of the cycle.
  assign empty    = (count_q == '0);
  assign full     = (count_q == CW'(NUM_REQ));
  assign pop      = cordic_dout_valid_in & ~empty;
  assign push     = handshake & (~full | pop);
  assign head_tag = fifo_mem[rd_ptr_q];

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < NUM_REQ; i++) fifo_mem[i] <= '0;
    end else begin
      if (push) begin
        fifo_mem[wr_ptr_q] <= tag_q;
        wr_ptr_q           <= wrap_inc(wr_ptr_q);
      end
      if (pop) rd_ptr_q <= wrap_inc(rd_ptr_q);
      case ({push, pop})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      resp_valid_out <= '0;
      resp_angle_out <= '0;
    end else begin
      resp_valid_out <= resp_valid_out & ~consume;
      if (pop) begin
        resp_valid_out[head_tag]                   <= 1'b1;
        resp_angle_out[int'(head_tag)*HW +: HW]    <= cordic_dout_in[DATA_WIDTH-1:HW];
      end
    end
  end

  assign unused_dout_lo = ^cordic_dout_in[HW-1:0];

`ifdef CORDIC_ARB_ERR_EN
  logic err_q;
  always_ff @(posedge clk_in or negedge rst_n_in) begin
    if (!rst_n_in) begin
      err_q <= 1'b0;
    end else if ((cordic_dout_valid_in && empty) || (handshake && full && !pop)) begin
      err_q <= 1'b1;
    end
  end
  assign err_out = err_q;
`else
  assign err_out = 1'b0;
`endif

endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: grant-order scoreboard, a one-cycle CORDIC model and hand-computed checks.
module tb_cordic_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int HW = 16;

  logic              clk_in = 1'b0;
  logic              rst_n_in;
  logic [N-1:0]      req_valid_in;
  logic [N*DW-1:0]   req_data_in;
  logic [N-1:0]      req_ready_out;
  logic [DW-1:0]     cordic_tdata_out;
  logic              cordic_tvalid_out;
  logic              cordic_tready_in;
  logic [DW-1:0]     cordic_dout_in;
  logic              cordic_dout_valid_in;
  logic [N*HW-1:0]   resp_angle_out;
  logic [N-1:0]      resp_valid_out;
  logic [N-1:0]      resp_ready_in;
  logic              err_out;

  logic [DW-1:0]     rd [N];
  logic [1:0]        exp_q [$];
  logic [DW-1:0]     hs_q [$];
  int                gc_q [$];
  logic [HW-1:0]     exp_angle [N];
  logic              model_en;
  logic              exp_err;
  int                n_cmp = 0;
  int                n_err = 0;
  int                n_resp = 0;
  int                cyc = 0;
  int                resp_base;

  assign req_data_in = {rd[3], rd[2], rd[1], rd[0]};

  cordic_arbiter #(.NUM_REQ(N), .DATA_WIDTH(DW)) dut (
    .clk_in               (clk_in),
    .rst_n_in             (rst_n_in),
    .req_valid_in         (req_valid_in),
    .req_data_in          (req_data_in),
    .req_ready_out        (req_ready_out),
    .cordic_tdata_out     (cordic_tdata_out),
    .cordic_tvalid_out    (cordic_tvalid_out),
    .cordic_tready_in     (cordic_tready_in),
    .cordic_dout_in       (cordic_dout_in),
    .cordic_dout_valid_in (cordic_dout_valid_in),
    .resp_angle_out       (resp_angle_out),
    .resp_valid_out       (resp_valid_out),
    .resp_ready_in        (resp_ready_in),
    .err_out              (err_out)
  );

  always #5 clk_in = ~clk_in;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  function automatic logic [HW-1:0] phase_of(input logic [DW-1:0] d);
    return d[DW-1:HW] + d[HW-1:0];
  endfunction

  // Mid-cycle sampling of grants and consumed responses, then advance to just after the next edge.
  task automatic step();
    logic [1:0]   g;
    logic [N-1:0] oh;
    @(negedge clk_in);
    if (model_en && cordic_tvalid_out && cordic_tready_in) hs_q.push_back(cordic_tdata_out);
    if (req_ready_out != '0) begin
      if (exp_q.size() == 0) begin
        check_eq("grant_unexpected", req_ready_out, 0);
      end else begin
        g = exp_q.pop_front();
        oh = '0;
        oh[g] = 1'b1;
        check_eq("grant", req_ready_out, oh);
        exp_angle[g] = phase_of(rd[g]);
        gc_q.push_back(cyc);
      end
    end
    for (int i = 0; i < N; i++) begin
      if (resp_valid_out[i] && resp_ready_in[i]) begin
        n_resp++;
        if (model_en) check_eq("resp_angle", resp_angle_out[i*HW +: HW], exp_angle[i]);
      end
    end
    @(posedge clk_in);
    #1;
    cyc++;
    if (model_en) begin
      if (hs_q.size() > 0) begin
        cordic_dout_in       = {phase_of(hs_q.pop_front()), 16'hBEEF};
        cordic_dout_valid_in = 1'b1;
      end else begin
        cordic_dout_valid_in = 1'b0;
      end
    end
  endtask

  task automatic do_reset();
    rst_n_in             = 1'b0;
    req_valid_in         = '0;
    cordic_tready_in     = 1'b0;
    cordic_dout_in       = '0;
    cordic_dout_valid_in = 1'b0;
    resp_ready_in        = '0;
    model_en             = 1'b0;
    exp_q.delete();
    hs_q.delete();
    repeat (2) @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
  endtask

  task automatic grant_one(input logic [1:0] idx);
    req_valid_in      = '0;
    req_valid_in[idx] = 1'b1;
    exp_q.push_back(idx);
    step();
    req_valid_in = '0;
    step();
  endtask

  initial begin
    for (int i = 0; i < N; i++) begin
      rd[i] = '0;
      exp_angle[i] = '0;
    end
    do_reset();

    // Reset state
    check_eq("rst_ready", req_ready_out, 0);
    check_eq("rst_tvalid", cordic_tvalid_out, 0);
    check_eq("rst_tdata", cordic_tdata_out, 0);
    check_eq("rst_resp_valid", resp_valid_out, 0);
    check_eq("rst_resp_angle", resp_angle_out, 0);
    check_eq("rst_err", err_out, 0);

    // Single request from requester 0
    rd[0] = 32'h0100_0100;
    req_valid_in = 4'b0001;
    cordic_tready_in = 1'b1;
    exp_q.push_back(2'd0);
    #1;
    check_eq("t1_ready_pulse", req_ready_out, 4'b0001);
    step();
    req_valid_in = '0;
    check_eq("t1_tvalid", cordic_tvalid_out, 1);
    check_eq("t1_tdata", cordic_tdata_out, 32'h0100_0100);
    step();
    check_eq("t1_tvalid_drop", cordic_tvalid_out, 0);
    cordic_dout_in = 32'h1921_5A5A;
    cordic_dout_valid_in = 1'b1;
    step();
    cordic_dout_valid_in = 1'b0;
    check_eq("t1_resp_valid", resp_valid_out, 4'b0001);
    check_eq("t1_angle0", resp_angle_out[15:0], 16'h1921);
    step();
    step();
    check_eq("t1_resp_held", resp_valid_out, 4'b0001);
    resp_ready_in = 4'b0001;
    step();
    resp_ready_in = '0;
    check_eq("t1_resp_cleared", resp_valid_out, 0);

    // All requesters continuously valid, immediate consumption
    do_reset();
    rd[0] = 32'h0100_0010;
    rd[1] = 32'h0200_0020;
    rd[2] = 32'h0300_0030;
    rd[3] = 32'h0400_0040;
    req_valid_in = 4'hF;
    resp_ready_in = 4'hF;
    cordic_tready_in = 1'b1;
    model_en = 1'b1;
    gc_q.delete();
    resp_base = n_resp;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd3, 2'd0, 2'd1};
    repeat (11) step();
    req_valid_in = '0;
    repeat (4) step();
    check_eq("t2_grant_count", gc_q.size(), 6);
    for (int i = 1; i < gc_q.size(); i++) check_eq("t2_grant_gap", gc_q[i] - gc_q[i-1], 2);
    check_eq("t2_resp_count", n_resp - resp_base, 6);
    model_en = 1'b0;
    cordic_dout_valid_in = 1'b0;
    resp_ready_in = '0;

    // Results returned to slots 2,0,3 in issue order
    grant_one(2'd2);
    grant_one(2'd0);
    grant_one(2'd3);
    cordic_dout_in = 32'h1111_0000;
    cordic_dout_valid_in = 1'b1;
    step();
    check_eq("t3_first_valid", resp_valid_out, 4'b0100);
    check_eq("t3_first_angle", resp_angle_out[32 +: 16], 16'h1111);
    cordic_dout_in = 32'h2222_0000;
    step();
    cordic_dout_in = 32'h3333_0000;
    step();
    cordic_dout_valid_in = 1'b0;
    check_eq("t3_all_valid", resp_valid_out, 4'b1101);
    check_eq("t3_angle2", resp_angle_out[32 +: 16], 16'h1111);
    check_eq("t3_angle0", resp_angle_out[0 +: 16], 16'h2222);
    check_eq("t3_angle3", resp_angle_out[48 +: 16], 16'h3333);
    resp_ready_in = 4'hF;
    step();
    resp_ready_in = '0;
    check_eq("t3_cleared", resp_valid_out, 0);

    // Requester 1 holds its result; 0 and 2 alternate until 1 consumes
    req_valid_in = 4'b0111;
    resp_ready_in = 4'b1101;
    model_en = 1'b1;
    exp_q = '{2'd0, 2'd1, 2'd2, 2'd0, 2'd2, 2'd0, 2'd2, 2'd0, 2'd1};
    repeat (15) step();
    check_eq("t4_req1_held", resp_valid_out[1], 1);
    resp_ready_in = 4'hF;
    step();
    step();
    req_valid_in = '0;
    repeat (4) step();
    check_eq("t4_grants_done", exp_q.size(), 0);

    // CORDIC backpressure while in ISSUE
    req_valid_in = 4'b0011;
    cordic_tready_in = 1'b0;
    exp_q.push_back(2'd0);
    step();
    for (int k = 0; k < 5; k++) begin
      check_eq("t5_tvalid_hold", cordic_tvalid_out, 1);
      check_eq("t5_tdata_hold", cordic_tdata_out, 32'h0100_0010);
      check_eq("t5_no_ready", req_ready_out, 0);
      step();
    end
    cordic_tready_in = 1'b1;
    exp_q.push_back(2'd1);
    step();
    check_eq("t5_tvalid_drop", cordic_tvalid_out, 0);
    step();
    req_valid_in = '0;
    repeat (4) step();
    check_eq("t5_grants_done", exp_q.size(), 0);
    model_en = 1'b0;
    cordic_dout_valid_in = 1'b0;
    resp_ready_in = '0;

    // Asynchronous reset with two results in flight
    `ifdef CORDIC_ARB_ERR_EN
    exp_err = 1'b1;
    `else
    exp_err = 1'b0;
    `endif
    grant_one(2'd2);
    grant_one(2'd3);
    check_eq("t6_pre_err", err_out, 0);
    #2;
    rst_n_in = 1'b0;
    #1;
    check_eq("t6_rst_tvalid", cordic_tvalid_out, 0);
    check_eq("t6_rst_resp_valid", resp_valid_out, 0);
    @(posedge clk_in);
    #1;
    rst_n_in = 1'b1;
    cordic_dout_in = 32'h7777_0000;
    cordic_dout_valid_in = 1'b1;
    step();
    step();
    cordic_dout_valid_in = 1'b0;
    step();
    check_eq("t6_no_resp", resp_valid_out, 0);
    check_eq("t6_no_angle", resp_angle_out, 0);
    check_eq("t6_err", err_out, exp_err);
    check_eq("final_exp_q_empty", exp_q.size(), 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
